// File: rtl/spi_sensor_poller_if.sv
// SPI master FIFO-side bus of the sensor poller.
// This bundle carries everything exchanged with the SPI master and the
// sensor chip select.
//   master : poller side. It drives CS, the TX push, the RX pop, the TX byte
//            and the mode constants.
//   slave  : SPI master side. It drives the RX head, the FIFO flags and the
//            transmission flag.
interface spi_sensor_poller_if #(
  parameter int DataWidth = 8
);
  logic                 SensorCS_n_o;
  logic                 SPI_Write_o;
  logic                 SPI_ReadNext_o;
  logic [DataWidth-1:0] SPI_Data_o;
  logic [DataWidth-1:0] SPI_Data_i;
  logic                 SPI_FIFOFull_i;
  logic                 SPI_FIFOEmpty_i;
  logic                 SPI_Transmission_i;
  logic                 SPI_CPOL_o;
  logic                 SPI_CPHA_o;
  logic                 SPI_LSBFE_o;

  modport master (
    output SensorCS_n_o, SPI_Write_o, SPI_ReadNext_o, SPI_Data_o,
           SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o,
    input  SPI_Data_i, SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i
  );

  modport slave (
    input  SensorCS_n_o, SPI_Write_o, SPI_ReadNext_o, SPI_Data_o,
           SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o,
    output SPI_Data_i, SPI_FIFOFull_i, SPI_FIFOEmpty_i, SPI_Transmission_i
  );
endinterface

// File: rtl/spi_sensor_poller.sv
// Periodic SPI sensor poller.
// A period timer triggers one sensor transaction. Each transaction pushes the
// command byte and ReadBytes dummy bytes, waits for the SPI master to shift
// them out, then pops the echo and the data bytes. The data bytes are
// assembled MSB-first. The assembled sample is then evaluated against a
// delta or window condition, and the block raises a one-cycle CPU interrupt
// whenever it reports a new value.
// Ports:
//   Clk_i, Reset_i        clock, asynchronous active-high reset
//   Enable_i              polling enable
//   Mode_i                0 = delta mode, 1 = window mode
//   PeriodPreset_i        period reload value in clocks
//   Threshold_i           delta threshold / window upper limit
//   LowerLimit_i          window lower limit
//   CpuIntr_o             one-cycle interrupt pulse
//   SensorValue_o         last reported value
//   Busy_o                SPI transaction in progress
//   spi (master modport)  chip select and SPI master FIFO interface
module spi_sensor_poller #(
  parameter int                   DataWidth  = 8,
  parameter int                   ReadBytes  = 2,
  parameter int                   TimerWidth = 32,
  parameter logic [DataWidth-1:0] CmdByte    = 8'h50,
  parameter bit                   SignedCmp  = 1'b1
)(
  input  logic                            Clk_i,
  input  logic                            Reset_i,
  input  logic                            Enable_i,
  input  logic                            Mode_i,
  input  logic [TimerWidth-1:0]           PeriodPreset_i,
  input  logic [DataWidth*ReadBytes-1:0]  Threshold_i,
  input  logic [DataWidth*ReadBytes-1:0]  LowerLimit_i,
  output logic                            CpuIntr_o,
  output logic [DataWidth*ReadBytes-1:0]  SensorValue_o,
  output logic                            Busy_o,
  spi_sensor_poller_if.master             spi
);
  localparam int VW = DataWidth*ReadBytes;
  // Byte index of the last byte in a frame: the command/echo byte is index 0.
  localparam logic [2:0]            LAST  = 3'(ReadBytes);
  localparam logic [2:0]            C_ONE = 3'd1;
  localparam logic [TimerWidth-1:0] T_ONE = TimerWidth'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_XSTART, S_XEND, S_READ, S_EVAL
  } state_t;

  state_t          state;
  logic [TimerWidth-1:0] timer;
  logic [2:0]      wr_cnt, rd_cnt;
  logic [VW-1:0]   sample, sample_nxt;
  logic            first, enable_q;
  logic            cs_n;
  logic            push, pop;

  assign spi.SPI_CPOL_o   = 1'b1;
  assign spi.SPI_CPHA_o   = 1'b1;
  assign spi.SPI_LSBFE_o  = 1'b0;
  assign spi.SensorCS_n_o = cs_n;

  // The push and pop strobes are qualified by the FIFO flags in the same
  // cycle. This way a full TX FIFO or an empty RX FIFO blocks a byte at once,
  // instead of one cycle late.
  assign push = (state == S_WRITE) && !spi.SPI_FIFOFull_i;
  assign pop  = (state == S_READ)  && !spi.SPI_FIFOEmpty_i;
  assign spi.SPI_Write_o    = push;
  assign spi.SPI_ReadNext_o = pop;
  assign spi.SPI_Data_o     = (push && wr_cnt == '0) ? CmdByte : '0;

  // MSB-first assembly. When only one byte is read, the new byte is the
  // whole sample.
  generate
    if (VW > DataWidth) begin : g_shift
      assign sample_nxt = {sample[VW-DataWidth-1:0], spi.SPI_Data_i};
    end else begin : g_single
      assign sample_nxt = spi.SPI_Data_i;
    end
  endgenerate

  // Report condition. All operands are extended by one bit so that the
  // difference and the window compares never overflow. With unsigned
  // compare, the zero extension makes the signed compares below behave as
  // unsigned ones.
  function automatic logic [VW:0] ext(input logic [VW-1:0] x);
    return SignedCmp ? {x[VW-1], x} : {1'b0, x};
  endfunction

  logic [VW:0] diff, mag;
  logic        win_hit, delta_hit, report;
  always_comb begin
    diff      = ext(sample) - ext(SensorValue_o);
    mag       = diff[VW] ? -diff : diff;
    // The delta threshold is a magnitude, so it is compared unsigned.
    delta_hit = mag > {1'b0, Threshold_i};
    win_hit   = ($signed(ext(sample)) > $signed(ext(Threshold_i))) ||
                ($signed(ext(sample)) < $signed(ext(LowerLimit_i)));
    report    = first || (Mode_i ? win_hit : delta_hit);
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state         <= S_IDLE;
      timer         <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      sample        <= '0;
      first         <= 1'b1;
      enable_q      <= 1'b0;
      cs_n          <= 1'b1;
      Busy_o        <= 1'b0;
      CpuIntr_o     <= 1'b0;
      SensorValue_o <= '0;
    end else begin
      enable_q  <= Enable_i;
      CpuIntr_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Enable_i) begin
            timer <= PeriodPreset_i;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (timer == '0) begin
            // Reload here, so the transaction time does not eat into the
            // next period.
            timer <= PeriodPreset_i;
            if (Enable_i) begin
              state  <= S_WRITE;
              wr_cnt <= '0;
              cs_n   <= 1'b0;
              Busy_o <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - T_ONE;
          end
        end
        S_WRITE: begin
          if (push) begin
            wr_cnt <= wr_cnt + C_ONE;
            if (wr_cnt == LAST) state <= S_XSTART;
          end
        end
        S_XSTART: if (spi.SPI_Transmission_i) state <= S_XEND;
        S_XEND: begin
          if (!spi.SPI_Transmission_i) begin
            state  <= S_READ;
            rd_cnt <= '0;
          end
        end
        S_READ: begin
          if (pop) begin
            rd_cnt <= rd_cnt + C_ONE;
            // Byte 0 is the command echo and is dropped.
            if (rd_cnt != '0) sample <= sample_nxt;
            if (rd_cnt == LAST) begin
              cs_n  <= 1'b1;
              state <= S_EVAL;
            end
          end
        end
        S_EVAL: begin
          if (report) begin
            SensorValue_o <= sample;
            CpuIntr_o     <= 1'b1;
          end
          Busy_o <= 1'b0;
          state  <= Enable_i ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A fresh enable always forces the next sample to be reported.
      if (Enable_i && !enable_q)        first <= 1'b1;
      else if (state == S_EVAL && report) first <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_sensor_poller.sv
`timescale 1ns/1ps
module tb_spi_sensor_poller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- instance 0: default parameters (16-bit value) -------------
  logic        rst0 = 1'b1, en0 = 1'b0, mode0 = 1'b0;
  logic        intr0, busy0;
  logic [31:0] pre0 = '0;
  logic [15:0] thr0 = '0, low0 = '0, val0;
  spi_sensor_poller_if #(.DataWidth(8)) sif0 ();
  spi_sensor_poller u0 (
    .Clk_i(clk), .Reset_i(rst0), .Enable_i(en0), .Mode_i(mode0),
    .PeriodPreset_i(pre0), .Threshold_i(thr0), .LowerLimit_i(low0),
    .CpuIntr_o(intr0), .SensorValue_o(val0), .Busy_o(busy0), .spi(sif0.master));

  // ---------------- instance 1: ReadBytes=1, TimerWidth=8 ---------------------
  logic        rst1 = 1'b1, en1 = 1'b0, mode1 = 1'b0;
  logic        intr1, busy1;
  logic [7:0]  pre1 = '0, thr1 = '0, low1 = '0, val1;
  spi_sensor_poller_if #(.DataWidth(8)) sif1 ();
  spi_sensor_poller #(.ReadBytes(1), .TimerWidth(8)) u1 (
    .Clk_i(clk), .Reset_i(rst1), .Enable_i(en1), .Mode_i(mode1),
    .PeriodPreset_i(pre1), .Threshold_i(thr1), .LowerLimit_i(low1),
    .CpuIntr_o(intr1), .SensorValue_o(val1), .Busy_o(busy1), .spi(sif1.master));

  // ---------------- SPI master model, instance 0 (3-byte frames) --------------
  logic [7:0] tx0 [64];
  logic [7:0] rx0 [16];
  logic [7:0] resp0 [3];
  logic [3:0] wp0 = '0, rp0 = '0;
  int         nwr0 = 0, base0 = 0, npop0 = 0, xc0 = 0, bad0 = 0, icnt0 = 0, cslow0 = 0;
  logic       xmit0 = 1'b0, full0 = 1'b0, fe0 = 1'b0;
  assign sif0.SPI_FIFOFull_i     = full0;
  assign sif0.SPI_FIFOEmpty_i    = (rp0 == wp0) || fe0;
  assign sif0.SPI_Data_i         = rx0[rp0];
  assign sif0.SPI_Transmission_i = xmit0;

  always @(posedge clk) begin
    if (rst0) begin
      base0 <= nwr0; rp0 <= wp0; xc0 <= 0; xmit0 <= 1'b0;
    end else begin
      if (sif0.SPI_Write_o) begin
        tx0[nwr0 % 64] <= sif0.SPI_Data_o;
        nwr0 <= nwr0 + 1;
      end
      if (nwr0 - base0 == 3) begin
        xc0 <= xc0 + 1;
        if (xc0 == 1) xmit0 <= 1'b1;
        if (xc0 == 5) begin
          xmit0 <= 1'b0; xc0 <= 0; base0 <= nwr0; wp0 <= wp0 + 4'd3;
          for (int i = 0; i < 3; i++) rx0[wp0 + 4'(i)] <= resp0[i];
        end
      end
      if (sif0.SPI_ReadNext_o) begin
        rp0 <= rp0 + 4'd1; npop0 <= npop0 + 1;
      end
      if ((sif0.SPI_Write_o && full0) || (sif0.SPI_ReadNext_o && sif0.SPI_FIFOEmpty_i))
        bad0 <= bad0 + 1;
      if (!sif0.SensorCS_n_o) cslow0 <= cslow0 + 1;
    end
    if (intr0) icnt0 <= icnt0 + 1;
  end

  // Flow-control stimulus for instance 0. A stall holds the TX FIFO full for
  // 5 cycles after the first push, and the RX empty flag toggles every cycle.
  logic rf0 = 1'b0, re0 = 1'b0, sf0 = 1'b0, se0 = 1'b0, tog0 = 1'b0;
  int   hold0 = 0;
  always @(negedge clk) begin
    tog0 = ~tog0;
    if (!busy0) hold0 = 0;
    if (sf0 && busy0 && (nwr0 - base0 == 1) && hold0 < 5) begin
      full0 = 1'b1; hold0 = hold0 + 1;
    end else begin
      full0 = rf0;
    end
    fe0 = re0 || (se0 && tog0);
  end

  // ---------------- SPI master model, instance 1 (2-byte frames) --------------
  logic [7:0] tx1 [64];
  logic [7:0] rx1 [16];
  logic [7:0] resp1 [2];
  logic [3:0] wp1 = '0, rp1 = '0;
  int         nwr1 = 0, base1 = 0, npop1 = 0, xc1 = 0, bad1 = 0, icnt1 = 0, cslow1 = 0;
  logic       xmit1 = 1'b0, rf1 = 1'b0, re1 = 1'b0;
  assign sif1.SPI_FIFOFull_i     = rf1;
  assign sif1.SPI_FIFOEmpty_i    = (rp1 == wp1) || re1;
  assign sif1.SPI_Data_i         = rx1[rp1];
  assign sif1.SPI_Transmission_i = xmit1;

  always @(posedge clk) begin
    if (rst1) begin
      base1 <= nwr1; rp1 <= wp1; xc1 <= 0; xmit1 <= 1'b0;
    end else begin
      if (sif1.SPI_Write_o) begin
        tx1[nwr1 % 64] <= sif1.SPI_Data_o;
        nwr1 <= nwr1 + 1;
      end
      if (nwr1 - base1 == 2) begin
        xc1 <= xc1 + 1;
        if (xc1 == 1) xmit1 <= 1'b1;
        if (xc1 == 5) begin
          xmit1 <= 1'b0; xc1 <= 0; base1 <= nwr1; wp1 <= wp1 + 4'd2;
          for (int i = 0; i < 2; i++) rx1[wp1 + 4'(i)] <= resp1[i];
        end
      end
      if (sif1.SPI_ReadNext_o) begin
        rp1 <= rp1 + 4'd1; npop1 <= npop1 + 1;
      end
      if ((sif1.SPI_Write_o && rf1) || (sif1.SPI_ReadNext_o && sif1.SPI_FIFOEmpty_i))
        bad1 <= bad1 + 1;
      if (!sif1.SensorCS_n_o) cslow1 <= cslow1 + 1;
    end
    if (intr1) icnt1 <= icnt1 + 1;
  end

  // Waits for one complete transaction (Busy rise, then fall), with bounds.
  task automatic wait_frame(input int k, output bit ok);
    int c;
    ok = 1'b0;
    c = 0;
    while (((k == 0) ? busy0 : busy1) == 1'b0 && c < 400) begin @(negedge clk); c++; end
    if (c >= 400) return;
    c = 0;
    while (((k == 0) ? busy0 : busy1) == 1'b1 && c < 300) begin @(negedge clk); c++; end
    ok = (c < 300);
  endtask

  typedef struct {
    bit          mode;
    logic [15:0] thr;
    logic [15:0] low;
    logic [15:0] smp;
    bit          stall;
    bit          exp_intr;
    logic [15:0] exp_val;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit ok;
    int wb, pb, ib, c;

    // mode, thr, low, sample, stall, intr, value
    tbl[0]  = '{1'b0, 16'h0020, 16'h0000, 16'h0C80, 1'b0, 1'b1, 16'h0C80}; // first sample
    tbl[1]  = '{1'b0, 16'h0020, 16'h0000, 16'h0C90, 1'b0, 1'b0, 16'h0C80}; // diff 0x10
    tbl[2]  = '{1'b0, 16'h0020, 16'h0000, 16'h0CA1, 1'b1, 1'b1, 16'h0CA1}; // diff 0x21, stalled FIFOs
    tbl[3]  = '{1'b0, 16'h0020, 16'h0000, 16'h0CC1, 1'b0, 1'b0, 16'h0CA1}; // diff == thr
    tbl[4]  = '{1'b0, 16'h0020, 16'h0000, 16'h0C80, 1'b0, 1'b1, 16'h0C80}; // diff -0x21
    tbl[5]  = '{1'b1, 16'h0100, 16'hFF00, 16'hFE00, 1'b0, 1'b1, 16'hFE00}; // below signed lower
    tbl[6]  = '{1'b1, 16'h0100, 16'hFF00, 16'h0050, 1'b0, 1'b0, 16'hFE00}; // inside window
    tbl[7]  = '{1'b1, 16'h0100, 16'hFF00, 16'h0101, 1'b1, 1'b1, 16'h0101}; // above upper
    tbl[8]  = '{1'b1, 16'h0100, 16'hFF00, 16'h0100, 1'b0, 1'b0, 16'h0101}; // == upper
    tbl[9]  = '{1'b1, 16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0, 16'h0101}; // == lower
    tbl[10] = '{1'b0, 16'h0020, 16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000}; // large signed delta
    tbl[11] = '{1'b0, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 16'h7FFF}; // 0xFFFF > 0x7FFF

    // ---- reset with random inputs ----
    repeat (8) begin
      @(negedge clk);
      en0 = 1'($urandom); mode0 = 1'($urandom); pre0 = $urandom;
      thr0 = 16'($urandom); low0 = 16'($urandom);
      rf0 = 1'($urandom); re0 = 1'($urandom);
      en1 = 1'($urandom); mode1 = 1'($urandom); pre1 = 8'($urandom);
      thr1 = 8'($urandom); low1 = 8'($urandom);
      rf1 = 1'($urandom); re1 = 1'($urandom);
    end
    #1;
    chk("rst_intr",   intr0, 0);
    chk("rst_value",  val0, 0);
    chk("rst_busy",   busy0, 0);
    chk("rst_cs_n",   sif0.SensorCS_n_o, 1);
    chk("rst_write",  sif0.SPI_Write_o, 0);
    chk("rst_readnx", sif0.SPI_ReadNext_o, 0);
    chk("rst_data",   sif0.SPI_Data_o, 0);
    chk("rst_modes",  {sif0.SPI_CPOL_o, sif0.SPI_CPHA_o, sif0.SPI_LSBFE_o}, 3'b110);
    chk("rst_cs_n1",  sif1.SensorCS_n_o, 1);

    @(negedge clk);
    en0 = 1'b0; en1 = 1'b0; rf0 = 1'b0; re0 = 1'b0; rf1 = 1'b0; re1 = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (1000) @(negedge clk);
    chk("idle_writes0", nwr0, 0);
    chk("idle_cslow0",  cslow0, 0);
    chk("idle_writes1", nwr1, 0);
    chk("idle_cslow1",  cslow1, 0);
    chk("idle_intr0",   icnt0, 0);

    // ---- table-driven transactions on instance 0 ----
    pre0 = 32'd100; thr0 = 16'h0020; low0 = 16'h0000; mode0 = 1'b0;
    for (int v = 0; v < 12; v++) begin
      mode0 = tbl[v].mode; thr0 = tbl[v].thr; low0 = tbl[v].low;
      resp0[0] = 8'h50; resp0[1] = tbl[v].smp[15:8]; resp0[2] = tbl[v].smp[7:0];
      sf0 = tbl[v].stall; se0 = tbl[v].stall;
      wb = nwr0; pb = npop0; ib = icnt0;
      en0 = 1'b1;
      wait_frame(0, ok);
      chk($sformatf("v%0d_frame_done", v), ok, 1);
      repeat (2) @(negedge clk);
      sf0 = 1'b0; se0 = 1'b0;
      chk($sformatf("v%0d_intr", v),   icnt0 - ib, tbl[v].exp_intr);
      chk($sformatf("v%0d_value", v),  val0, tbl[v].exp_val);
      chk($sformatf("v%0d_writes", v), nwr0 - wb, 3);
      chk($sformatf("v%0d_tx0", v),    tx0[wb % 64], 8'h50);
      chk($sformatf("v%0d_tx12", v),   {tx0[(wb + 1) % 64], tx0[(wb + 2) % 64]}, 16'h0000);
      chk($sformatf("v%0d_pops", v),   npop0 - pb, 3);
    end
    en0 = 1'b0;

    // ---- instance 1: 1-byte reads, enable dropped in XEND ----
    pre1 = 8'd20; thr1 = 8'h05; low1 = 8'h00; mode1 = 1'b0;
    resp1[0] = 8'h50; resp1[1] = 8'h7A;
    wb = nwr1; pb = npop1; ib = icnt1;
    en1 = 1'b1;
    wait_frame(1, ok);
    chk("i1_frame_done", ok, 1);
    repeat (2) @(negedge clk);
    chk("i1_first_intr", icnt1 - ib, 1);
    chk("i1_value",      val1, 8'h7A);
    chk("i1_writes",     nwr1 - wb, 2);
    chk("i1_tx",         {tx1[wb % 64], tx1[(wb + 1) % 64]}, 16'h5000);
    chk("i1_pops",       npop1 - pb, 2);

    resp1[1] = 8'h10;
    ib = icnt1;
    c = 0;
    while (!xmit1 && c < 400) begin @(negedge clk); c++; end
    chk("i1_xmit_seen", (c < 400), 1);
    @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    chk("i1_cs_held", sif1.SensorCS_n_o, 0);
    c = 0;
    while (busy1 && c < 300) begin @(negedge clk); c++; end
    chk("i1_frame_end", (c < 300), 1);
    chk("i1_cs_release", sif1.SensorCS_n_o, 1);
    repeat (2) @(negedge clk);
    chk("i1_eval_intr", icnt1 - ib, 1);
    chk("i1_eval_value", val1, 8'h10);
    wb = nwr1; ib = icnt1;
    repeat (100) @(negedge clk);
    chk("i1_idle_writes", nwr1 - wb, 0);
    chk("i1_idle_busy",   busy1, 0);

    // ---- instance 1: reset pulsed while stalled in READ ----
    resp1[1] = 8'h33;
    re1 = 1'b1;
    ib = icnt1;
    en1 = 1'b1;
    c = 0;
    while (!xmit1 && c < 400) begin @(negedge clk); c++; end
    while (xmit1 && c < 400) begin @(negedge clk); c++; end
    chk("i1_read_reached", (c < 400), 1);
    repeat (3) @(negedge clk);
    chk("i1_read_cs", sif1.SensorCS_n_o, 0);
    chk("i1_read_busy", busy1, 1);
    rst1 = 1'b1;
    #1;
    chk("i1_rst_cs_n", sif1.SensorCS_n_o, 1);
    chk("i1_rst_busy", busy1, 0);
    repeat (3) @(negedge clk);
    en1 = 1'b0; re1 = 1'b0;
    rst1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("i1_rst_no_intr", icnt1 - ib, 0);
    chk("i1_rst_value",   val1, 0);

    chk("flowctl_bad0", bad0, 0);
    chk("flowctl_bad1", bad1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/spi_sensor_poller.md
Name: spi_sensor_poller

Overview:
Generalised periodic SPI sensor poller, successor to the fixed 16-bit ADT7310 application. It combines the SPI byte sequencer and the sensor-evaluation FSM into one block with parametrised read length, timer width and compare mode. A periodic timer starts a read command to the sensor through the SPI master FIFO interface, then assembles the result and raises a CPU interrupt when the change/window condition is met. It sits in the reconfigurable module next to the SPI master.

Parameters:
DataWidth, 8, SPI byte width
ReadBytes, 2, number of data bytes read after the command byte (1..4); ValueWidth = DataWidth*ReadBytes
TimerWidth, 32, period counter width
CmdByte, 8'h50, command byte sent first (ADT7310 read temperature register)
SignedCmp, 1, 1 = two's-complement compare, 0 = unsigned

Ports:
Clk_i  in  1  clock
Reset_i  in  1  asynchronous active-high reset
Enable_i  in  1  polling enable
Mode_i  in  1  0 = delta mode, 1 = window mode
PeriodPreset_i  in  TimerWidth  period reload value in clocks
Threshold_i  in  ValueWidth  delta threshold (delta mode) / upper limit (window mode)
LowerLimit_i  in  ValueWidth  lower limit (window mode only)
CpuIntr_o  out  1  one-cycle interrupt pulse
SensorValue_o  out  ValueWidth  last reported value
Busy_o  out  1  SPI transaction in progress
SensorCS_n_o  out  1  sensor chip select, active low
SPI_Write_o  out  1  push SPI_Data_o into TX FIFO
SPI_ReadNext_o  out  1  pop RX FIFO
SPI_Data_o  out  DataWidth  TX byte
SPI_Data_i  in  DataWidth  RX FIFO head
SPI_FIFOFull_i  in  1  TX FIFO full
SPI_FIFOEmpty_i  in  1  RX FIFO empty
SPI_Transmission_i  in  1  SPI master shifting
SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o  out  1 each  constants 1, 1, 0

Behaviour:
- Reset: all state cleared asynchronously. Outputs after reset: CpuIntr_o=0, SensorValue_o=0, Busy_o=0, SensorCS_n_o=1, SPI_Write_o=0, SPI_ReadNext_o=0, SPI_Data_o=0. FSM goes to IDLE, timer=0, the "first" flag is set.
- IDLE: Enable_i=1 -> timer loads PeriodPreset_i and the FSM goes to WAIT. Any 0->1 edge of Enable_i sets "first".
- WAIT: the timer decrements each cycle. When timer==0 it reloads and the FSM goes to WRITE; if Enable_i=0, the FSM goes to IDLE instead. PeriodPreset_i=0 -> back-to-back transactions.
- WRITE: SensorCS_n_o=0 and Busy_o=1. The block pushes ReadBytes+1 bytes: CmdByte first, then 0x00 for each remaining byte. SPI_Write_o is high one cycle per byte and is held low while SPI_FIFOFull_i=1 (no byte lost or duplicated). After the last push the FSM goes to XSTART.
- XSTART: wait for SPI_Transmission_i=1, then go to XEND.
- XEND: wait for SPI_Transmission_i=0, then go to READ.
- READ: pops ReadBytes+1 bytes, one SPI_ReadNext_o pulse per byte, and only when SPI_FIFOEmpty_i=0. The first byte (command echo) is discarded. Remaining bytes are shifted in MSB-first into the sample register. After the last pop: SensorCS_n_o=1 and the FSM goes to EVAL.
- EVAL (1 cycle), with the report condition R:
  - "first" set -> R=1.
  - delta mode: R = |sample - SensorValue_o| > Threshold_i, computed at ValueWidth+1 bits (signedness per SignedCmp), strictly greater.
  - window mode: R = sample > Threshold_i or sample < LowerLimit_i.
  - R=1 -> SensorValue_o <= sample, CpuIntr_o=1 for exactly the next cycle, "first" cleared.
  - Busy_o drops. Next state is WAIT if Enable_i=1, otherwise IDLE.
- Disable during WRITE..EVAL: the transaction completes, including CS release and EVAL, then the FSM goes to IDLE. CS is never dropped mid-frame by disable.
- Reset mid-transaction: immediate, CS high, no interrupt.
- The timer counts only in WAIT. Transaction length does not shorten the next period.

Test Plan:
1. Reset asserted with random inputs -> all outputs at reset values, CS_n=1; released with Enable=0 -> no SPI activity for 1000 cycles.
2. Defaults, PeriodPreset=100, Enable=1, SPI model returns 0x50, 0x0C, 0x80 -> writes 0x50, 0x00, 0x00; SensorValue_o=0x0C80; one CpuIntr_o pulse (first sample); next sample 0x0C90 with Threshold=0x20 -> no interrupt.
3. Delta mode, SensorValue=0x0C80, Threshold=0x20, sample 0x0CA1 -> interrupt, value 0x0CA1. Sample exactly 0x0CC1 (diff=0x20) -> no interrupt.
4. Window mode, SignedCmp=1, Lower=0xFF00, Upper=0x0100, sample 0xFE00 (negative) -> interrupt; sample 0x0050 -> none.
5. SPI_FIFOFull_i held high 5 cycles mid-WRITE and SPI_FIFOEmpty_i toggled during READ -> exactly ReadBytes+1 writes and pops, correct assembled value.
6. ReadBytes=1, TimerWidth=8: 1 command + 1 data byte, 8-bit value; Enable dropped in XEND -> EVAL runs, CS rises, then IDLE. Reset pulsed in READ -> CS_n=1 immediately and no interrupt.
